// File: rtl/lcv_mul_acc_pipe.sv
// lcv_mul_acc_pipe: 3-stage pipelined signed/unsigned multiply-accumulate with valid/ready flow control.
// Define LCV_MUL_ACC_SAT_EN for saturating accumulation with a sticky overflow flag.
module lcv_mul_acc_pipe #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic                 in_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf
);
  localparam int PW = 2 * WIDTH;
  logic                 adv, v1, s1, c1, v2, s2, c2;
  logic [WIDTH-1:0]     a1, b1;
  logic [PW-1:0]        p2, prod;
  logic [ACC_WIDTH-1:0] acc, ext, base, nxt;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_acc  = acc;
  // Extending both operands to PW bits makes one multiplier serve signed and unsigned modes.
  assign prod = {{WIDTH{s1 & a1[WIDTH-1]}}, a1} * {{WIDTH{s1 & b1[WIDTH-1]}}, b1};
  assign ext  = {{(ACC_WIDTH-PW){s2 & p2[PW-1]}}, p2};
  assign base = c2 ? '0 : acc;
`ifdef LCV_MUL_ACC_SAT_EN
  logic [ACC_WIDTH:0] sum;
  logic               o, ovf;
  assign sum     = {base[ACC_WIDTH-1], base} + {ext[ACC_WIDTH-1], ext};
  assign o       = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
  assign nxt     = o ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){!sum[ACC_WIDTH]}}} : sum[ACC_WIDTH-1:0];
  assign out_ovf = ovf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf <= 1'b0;
    else if (adv && v2) ovf <= (!c2 && ovf) || o;
`else
  assign nxt     = base + ext;
  assign out_ovf = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      s1        <= 1'b0;
      c1        <= 1'b0;
      v2        <= 1'b0;
      p2        <= '0;
      s2        <= 1'b0;
      c2        <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      a1        <= in_a;
      b1        <= in_b;
      s1        <= in_signed;
      c1        <= in_clr;
      v2        <= v1;
      p2        <= prod;
      s2        <= s1;
      c2        <= c1;
      out_valid <= v2;
      if (v2) acc <= nxt;
    end
endmodule
